// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the control FSM.
//   - default address/data/displacement widths
//   - fetch state encoding
//   - 4-bit opcode and branch-condition constants decoded by the controller
package cpu_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  localparam int DISP_W_DEF = 8;

  // Encoding is fixed because the controller decodes it directly.
  typedef enum logic [1:0] {
    FS_IDLE = 2'b00,
    FS_ADDR = 2'b01,
    FS_CAPT = 2'b10
  } fetch_state_t;

  // Opcode field (ir[15:12]).
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BR   = 4'h8;
  localparam logic [3:0] OP_BRR  = 4'h9;
  localparam logic [3:0] OP_JAL  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Branch condition field.
  localparam logic [3:0] COND_AL = 4'h0;
  localparam logic [3:0] COND_EQ = 4'h1;
  localparam logic [3:0] COND_NE = 4'h2;
  localparam logic [3:0] COND_LT = 4'h3;
  localparam logic [3:0] COND_GE = 4'h4;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next: combinational next-PC selection for the fetch stage.
//   pc           current program counter
//   increment    advance to pc+1 (capture of a fetched word)
//   redirect     branch taken; has priority over increment
//   redirect_rel 1 = pc + sign-extended br_disp, 0 = br_target
//   br_target    absolute target
//   br_disp      signed displacement
//   next_pc      resulting PC; all arithmetic wraps modulo 2^ADDR_W
module pc_next
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DISP_W = DISP_W_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              increment,
  input  logic              redirect,
  input  logic              redirect_rel,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [DISP_W-1:0] br_disp,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] disp_ext;

  // Sign extension: low bits copy the displacement, the rest replicate its MSB.
  generate
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_sext
      if (gi < DISP_W) begin : g_low
        assign disp_ext[gi] = br_disp[gi];
      end else begin : g_high
        assign disp_ext[gi] = br_disp[DISP_W-1];
      end
    end
  endgenerate

  always_comb begin
    next_pc = pc;
    if (redirect) begin
      if (redirect_rel) begin
        next_pc = pc + disp_ext;
      end else begin
        next_pc = br_target;
      end
    end else if (increment) begin
      next_pc = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage ahead of the control FSM.
// Owns the PC, sequences a synchronous-read fetch over memory port A
// (IDLE -> ADDR -> CAPT -> IDLE), latches the word into ir and pulses
// instr_valid for one cycle. Branch redirects from the controller update the
// PC in any state and abort an in-flight fetch.
//   clk, reset     clock, synchronous active-high reset
//   fetch_req      request next instruction (sampled in IDLE only)
//   redirect       branch taken pulse; redirect_rel selects relative/absolute
//   br_target      absolute target; br_disp signed relative displacement
//   pc_sel         IDLE only: 1 = mem_addr from pc, 0 = from data_addr
//   data_addr      load/store address
//   mem_q          memory read data, valid one cycle after the address
//   mem_addr       memory port A address (combinational)
//   ir             instruction register
//   instr_valid    one-cycle pulse when ir holds a new instruction
//   pc             program counter
//   link           address of last fetched instruction + 1
//   fetch_busy     high in ADDR and CAPT
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter int              DATA_W    = DATA_W_DEF,
  parameter int              DISP_W    = DISP_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              redirect,
  input  logic              redirect_rel,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [DISP_W-1:0] br_disp,
  input  logic              pc_sel,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] ir,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link,
  output logic              fetch_busy
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_calc_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic [ADDR_W-1:0] link_reg, link_next;
  logic              valid_reg, valid_next;
  logic              increment;

  pc_next #(
    .ADDR_W (ADDR_W),
    .DISP_W (DISP_W)
  ) u_pc_next (
    .pc           (pc_reg),
    .increment    (increment),
    .redirect     (redirect),
    .redirect_rel (redirect_rel),
    .br_target    (br_target),
    .br_disp      (br_disp),
    .next_pc      (pc_calc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FS_IDLE;
      pc_reg    <= RESET_VEC;
      ir_reg    <= '0;
      link_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_calc_next;
      ir_reg    <= ir_next;
      link_reg  <= link_next;
      valid_reg <= valid_next;
    end
  end

  // A redirect in ADDR or CAPT drops the in-flight fetch: nothing is captured
  // and the PC takes the branch target instead of pc+1. In IDLE a redirect
  // coexists with fetch_req so the accepted fetch reads the new target.
  always_comb begin
    state_next = state_reg;
    ir_next    = ir_reg;
    link_next  = link_reg;
    valid_next = 1'b0;
    increment  = 1'b0;
    mem_addr   = pc_reg;
    case (state_reg)
      FS_IDLE: begin
        if (!pc_sel) begin
          mem_addr = data_addr;
        end
        if (fetch_req) begin
          state_next = FS_ADDR;
        end
      end
      FS_ADDR: begin
        state_next = redirect ? FS_IDLE : FS_CAPT;
      end
      FS_CAPT: begin
        state_next = FS_IDLE;
        if (!redirect) begin
          increment  = 1'b1;
          ir_next    = mem_q;
          link_next  = pc_calc_next;  // pc+1 with wrap
          valid_next = 1'b1;
        end
      end
      default: begin
        state_next = FS_IDLE;
      end
    endcase
  end

  assign ir          = ir_reg;
  assign instr_valid = valid_reg;
  assign pc          = pc_reg;
  assign link        = link_reg;
  assign fetch_busy  = (state_reg == FS_ADDR) || (state_reg == FS_CAPT);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed stimulus with a scoreboard. Each issued
// fetch pushes its expected {ir, pc, link} into a queue; a monitor pops and
// compares on every instr_valid pulse. Direct checks cover reset state,
// redirects, address muxing and abort behaviour.
module tb_fetch_unit;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int PW = 8;

  typedef struct {
    logic [DW-1:0] ir;
    logic [AW-1:0] pc;
    logic [AW-1:0] link;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic          redirect;
  logic          redirect_rel;
  logic [AW-1:0] br_target;
  logic [PW-1:0] br_disp;
  logic          pc_sel;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] mem_q;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] ir;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW-1:0] link;
  logic          fetch_busy;

  logic [DW-1:0] mem [0:65535];
  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  logic          mon_en   = 1'b0;

  fetch_unit #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .DISP_W    (PW),
    .RESET_VEC (16'h0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .redirect     (redirect),
    .redirect_rel (redirect_rel),
    .br_target    (br_target),
    .br_disp      (br_disp),
    .pc_sel       (pc_sel),
    .data_addr    (data_addr),
    .mem_q        (mem_q),
    .mem_addr     (mem_addr),
    .ir           (ir),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .link         (link),
    .fetch_busy   (fetch_busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory model.
  always @(posedge clk) mem_q <= mem[mem_addr];

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 16'h0000) return 16'h4C0E;
    return a ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (mon_en && instr_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_instr_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_ir", {16'h0, ir}, {16'h0, e.ir});
        chk("sb_pc", {16'h0, pc}, {16'h0, e.pc});
        chk("sb_link", {16'h0, link}, {16'h0, e.link});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic redir_abs(input logic [AW-1:0] t);
    redirect = 1'b1; redirect_rel = 1'b0; br_target = t;
    tick();
    redirect = 1'b0; br_target = 16'hDEAD;
  endtask

  task automatic redir_rel(input logic [PW-1:0] d);
    redirect = 1'b1; redirect_rel = 1'b1; br_disp = d;
    tick();
    redirect = 1'b0; redirect_rel = 1'b0; br_disp = 8'h00;
  endtask

  // Full fetch of address a; optionally with a same-cycle absolute redirect to a.
  task automatic do_fetch(input string name, input logic [AW-1:0] a, input logic with_redir);
    exp_t e;
    logic [AW-1:0] a1;
    a1 = a + 16'd1;
    e.ir = mem_val(a); e.pc = a1; e.link = a1;
    sb_q.push_back(e);
    fetch_req = 1'b1;
    if (with_redir) begin
      redirect = 1'b1; redirect_rel = 1'b0; br_target = a;
    end
    tick();
    fetch_req = 1'b0; redirect = 1'b0; br_target = 16'hDEAD;
    chk({name, "_addr_memaddr"}, {16'h0, mem_addr}, {16'h0, a});
    chk({name, "_addr_busy"}, {31'h0, fetch_busy}, 32'd1);
    tick();
    chk({name, "_capt_busy"}, {31'h0, fetch_busy}, 32'd1);
    chk({name, "_capt_novalid"}, {31'h0, instr_valid}, 32'd0);
    tick();
    chk({name, "_valid_pulse"}, {31'h0, instr_valid}, 32'd1);
    chk({name, "_idle_busy"}, {31'h0, fetch_busy}, 32'd0);
    tick();
    chk({name, "_valid_end"}, {31'h0, instr_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = mem_val(16'(i));
    reset = 1'b1; fetch_req = 1'b0; redirect = 1'b0; redirect_rel = 1'b0;
    br_target = 16'h0; br_disp = 8'h0; pc_sel = 1'b0; data_addr = 16'hBEEF;

    // Reset state.
    tick(); tick();
    chk("rst_pc", {16'h0, pc}, 32'h0);
    chk("rst_ir", {16'h0, ir}, 32'h0);
    chk("rst_link", {16'h0, link}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_busy", {31'h0, fetch_busy}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Single fetch from RESET_VEC.
    do_fetch("f0", 16'h0000, 1'b0);

    // Absolute redirects in IDLE, then fetch.
    redir_abs(16'h0005);
    chk("abs_pc5", {16'h0, pc}, 32'h0005);
    redir_abs(16'h0040);
    chk("abs_pc40", {16'h0, pc}, 32'h0040);
    do_fetch("f40", 16'h0040, 1'b0);

    // Relative redirects with wrap.
    redir_abs(16'h0002);
    redir_rel(8'hFC);
    chk("rel_neg_wrap", {16'h0, pc}, 32'hFFFE);
    redir_rel(8'h05);
    chk("rel_pos_wrap", {16'h0, pc}, 32'h0003);
    redir_rel(8'h7F);
    chk("rel_pos_max", {16'h0, pc}, 32'h0082);
    redir_rel(8'h80);
    chk("rel_neg_max", {16'h0, pc}, 32'h0002);
    redir_abs(16'hFFFF);
    do_fetch("fffff", 16'hFFFF, 1'b0);
    chk("wrap_pc0", {16'h0, pc}, 32'h0000);

    // Redirect during ADDR aborts the fetch.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    redir_abs(16'h0100);
    chk("abort_addr_pc", {16'h0, pc}, 32'h0100);
    chk("abort_addr_busy", {31'h0, fetch_busy}, 32'd0);
    tick(); tick();
    chk("abort_addr_ir", {16'h0, ir}, {16'h0, mem_val(16'hFFFF)});
    chk("abort_addr_link", {16'h0, link}, 32'h0000);

    // Relative redirect during CAPT aborts, computed from the current pc.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    redir_rel(8'h10);
    chk("abort_capt_pc", {16'h0, pc}, 32'h0110);
    chk("abort_capt_busy", {31'h0, fetch_busy}, 32'd0);
    tick(); tick();
    chk("abort_capt_ir", {16'h0, ir}, {16'h0, mem_val(16'hFFFF)});

    // fetch_req held while busy is not queued.
    fetch_req = 1'b1;
    sb_q.push_back('{ir: mem_val(16'h0110), pc: 16'h0111, link: 16'h0111});
    tick(); tick(); tick();
    fetch_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("noqueue_pc", {16'h0, pc}, 32'h0111);
    chk("noqueue_busy", {31'h0, fetch_busy}, 32'd0);

    // Simultaneous redirect and fetch_req in IDLE.
    do_fetch("sim", 16'h0020, 1'b1);
    chk("sim_pc", {16'h0, pc}, 32'h0021);

    // Address mux in IDLE.
    pc_sel = 1'b0; data_addr = 16'h1234;
    #1;
    chk("mux_data", {16'h0, mem_addr}, 32'h1234);
    pc_sel = 1'b1;
    #1;
    chk("mux_pc", {16'h0, mem_addr}, 32'h0021);
    pc_sel = 1'b0; data_addr = 16'hBEEF;

    // Reset asserted during CAPT.
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstcapt_pc", {16'h0, pc}, 32'h0000);
    chk("rstcapt_valid", {31'h0, instr_valid}, 32'd0);
    chk("rstcapt_busy", {31'h0, fetch_busy}, 32'd0);
    chk("rstcapt_ir", {16'h0, ir}, 32'h0);
    tick();
    chk("rstcapt_valid2", {31'h0, instr_valid}, 32'd0);

    // Normal operation after reset.
    do_fetch("post", 16'h0000, 1'b0);

    tick(); tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the main control FSM.
- Owns the program counter.
- Sequences synchronous-read instruction fetches from the unified memory port A.
- Latches the fetched word into an instruction register and hands it to the controller with a one-cycle valid pulse.
- Applies absolute or PC-relative branch redirects issued by the controller.
- Multiplexes the memory address between PC and the controller's data address for load/store.

Parameters:
ADDR_W, 16, PC and memory address width
DATA_W, 16, instruction/memory word width
DISP_W, 8, signed branch displacement width
RESET_VEC, 0, PC value after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
fetch_req  in  1  controller requests next instruction; sampled only in IDLE
redirect  in  1  branch taken; one-cycle pulse
redirect_rel  in  1  1 = PC-relative redirect, 0 = absolute; qualified by redirect
br_target  in  ADDR_W  absolute target (register value)
br_disp  in  DISP_W  signed displacement for relative redirect
pc_sel  in  1  1 = memory address from PC, 0 = from data_addr (IDLE only)
data_addr  in  ADDR_W  load/store address from register file
mem_q  in  DATA_W  memory read data; valid one cycle after address
mem_addr  out  ADDR_W  memory port A address
ir  out  DATA_W  instruction register
instr_valid  out  1  one-cycle pulse: ir holds a newly fetched instruction
pc  out  ADDR_W  current program counter
link  out  ADDR_W  return address of the last fetched instruction (its address + 1)
fetch_busy  out  1  high in ADDR and CAPT states

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - pc=RESET_VEC, ir=0, link=0, instr_valid=0, state=IDLE.
  - Overrides all other inputs, including mid-fetch.
- States:
  - IDLE:
    - fetch_req=1 -> ADDR.
    - Otherwise stay.
  - ADDR:
    - mem_addr=pc, so memory registers the address this cycle.
    - Always -> CAPT.
  - CAPT:
    - ir<=mem_q, link<=pc+1, pc<=pc+1, instr_valid<=1 (visible the following cycle for exactly one cycle).
    - -> IDLE.
- Fetch latency: fetch_req in IDLE at edge N -> instr_valid high during cycle N+3. Back-to-back fetches sustain one instruction per 3 cycles.
- mem_addr is combinational:
  - State != IDLE -> pc.
  - IDLE -> pc_sel ? pc : data_addr.
- fetch_busy = (state==ADDR || state==CAPT).
- Redirect next-PC:
  - Absolute: pc <= br_target.
  - Relative: pc <= pc + sign_extend(br_disp).
  - All PC arithmetic is modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000, and negative displacement below 0 wraps.
- Redirect in IDLE, no fetch_req: pc updated; stay IDLE.
- Redirect and fetch_req in the same cycle in IDLE: pc takes the target; fetch accepted -> ADDR. The fetch uses the new pc.
- Redirect in ADDR or CAPT: in-flight fetch aborted.
  - ir, link and instr_valid unchanged/not pulsed.
  - pc <= target. Relative redirects are computed from the pc value in that cycle.
  - -> IDLE.
- fetch_req outside IDLE is ignored; it is not queued.
- br_* inputs are don't-care when redirect=0.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W/DATA_W defaults
  - fetch state encoding (IDLE=2'b00, ADDR=2'b01, CAPT=2'b10)
  - the 4-bit opcode/condition constants already used by the control FSM
- One natural sub-module, pc_next: a combinational next-PC adder with inputs pc, increment, redirect, redirect_rel, br_target and br_disp. It is unit-tested standalone for sign extension and wrap.

Test Plan:
- Reset then single fetch: RESET_VEC=0, mem[0]=16'h4C0E, fetch_req pulse -> mem_addr=0 in ADDR; ir=16'h4C0E, instr_valid single pulse 3 cycles after request; pc=1, link=1.
- Absolute redirect in IDLE: pc=5, redirect=1, redirect_rel=0, br_target=16'h0040, then fetch -> mem_addr=0x0040; ir=mem[0x40]; pc=0x0041.
- Relative redirect with wrap: pc=0x0002, br_disp=8'hFC (-4) -> pc=0xFFFE. Separately pc=0xFFFF plus a fetch -> pc=0x0000.
- Redirect aborts fetch: fetch_req, then redirect with br_target=0x0100 during ADDR -> no instr_valid pulse; ir unchanged; state IDLE; pc=0x0100.
- Simultaneous redirect + fetch_req in IDLE: br_target=0x0020 -> fetch reads address 0x0020; pc=0x0021 after capture.
- Data address mux and reset mid-fetch:
  - IDLE with pc_sel=0, data_addr=0x1234 -> mem_addr=0x1234.
  - pc_sel=1 -> mem_addr=pc.
  - reset asserted in CAPT -> pc=RESET_VEC, instr_valid=0, IDLE next cycle.
